// File: rtl/booth_multiplier.sv
// booth_multiplier: sequential signed multiplier, radix-4 Booth recoding,
// one Booth digit per clock, start/busy/done handshake, registered result.
module booth_multiplier #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result
);

   localparam int unsigned PW     = 2 * WIDTH;
   localparam int unsigned DIGITS = WIDTH / 2;
   localparam int unsigned CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic [PW-1:0]     a_q,      a_d;      // sign-extended multiplicand, pre-shifted by 2i
   logic [WIDTH:0]    b_q,      b_d;      // {b, 1'b0}, shifted right by 2 per digit
   logic [PW-1:0]     acc_q,    acc_d;
   logic [PW-1:0]     result_q, result_d;
   logic              busy_q,   busy_d;
   logic              done_q,   done_d;

   logic [PW-1:0]     pp;
   logic [PW-1:0]     acc_sum;

   // Booth recoding of the current triplet into a partial product
   always_comb begin
      pp = '0;
      unique case (b_q[2:0])
         3'b001, 3'b010: pp = a_q;
         3'b011:         pp = a_q << 1;
         3'b100:         pp = -(a_q << 1);
         3'b101, 3'b110: pp = -a_q;
         default:        pp = '0;
      endcase
   end

   assign acc_sum = acc_q + pp;

   // Next-state and datapath update
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      result_d = result_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = {{WIDTH{a[WIDTH-1]}}, a};
               b_d     = {b, 1'b0};
               acc_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            acc_d = acc_sum;
            a_d   = a_q << 2;
            b_d   = b_q >> 2;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_DIGIT) begin
               result_d = acc_sum;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers; synchronous reset aborts any operation
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// tb_booth_multiplier: directed vectors with literal expectations plus a
// cycle-level behavioural model compared against the DUT every cycle.
module tb_booth_multiplier;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned LAT   = WIDTH / 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   result;

   int n_vec = 0;
   int n_err = 0;
   bit cmp_en = 1'b0;

   // model state (value expected after each rising edge)
   bit          m_busy = 1'b0;
   bit          m_done = 1'b0;
   logic [63:0] m_result = '0;
   logic [63:0] m_prod = '0;
   int          m_cycles = 0;

   booth_multiplier #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] smul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      longint sx;
      longint sy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
   endfunction

   // Behavioural model: accept when idle, deliver exact product LAT edges later
   always @(posedge clk) begin
      if (rst) begin
         m_busy   = 1'b0;
         m_done   = 1'b0;
         m_result = '0;
         m_cycles = 0;
      end else begin
         m_done = 1'b0;
         if (!m_busy) begin
            if (start) begin
               m_busy   = 1'b1;
               m_cycles = 0;
               m_prod   = smul(a, b);
            end
         end else begin
            m_cycles++;
            if (m_cycles == LAT) begin
               m_busy   = 1'b0;
               m_done   = 1'b1;
               m_result = m_prod;
            end
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_busy",   64'(busy),  64'(m_busy));
         chk("model_done",   64'(done),  64'(m_done));
         chk("model_result", result,     m_result);
         if (busy && done) chk("busy_and_done", 64'(1), 64'(0));
      end
   end

   task automatic launch(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi);
      start = 1'b1;
      a     = ai;
      b     = bi;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int k);
      k = 0;
      while (k < 4 * LAT) begin
         @(posedge clk);
         #1;
         k++;
         if (done) break;
      end
      if (!done) chk("done_timeout", 64'(0), 64'(1));
   endtask

   task automatic run_op(input string name, input logic [WIDTH-1:0] ai,
                         input logic [WIDTH-1:0] bi, input logic [63:0] exp);
      int k;
      launch(ai, bi);
      wait_done(k);
      chk({name, "_latency"}, 64'(k), 64'(LAT));
      chk(name, result, exp);
   endtask

   initial begin
      int k;
      bit saw_done;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      @(posedge clk);
      #1;
      cmp_en = 1'b1;
      chk("reset_result", result, 64'h0);
      chk("reset_done",   64'(done), 64'(0));
      chk("reset_busy",   64'(busy), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_result", result, 64'h0);

      // model pins: the model's arithmetic against hand-computed values
      chk("model_pin_1", smul(32'd50, -32'sd40),          64'hFFFFFFFFFFFFF830);
      chk("model_pin_2", smul(32'h80000000, 32'h80000000), 64'h4000000000000000);

      run_op("mix_50_m40",    32'd50,    -32'sd40,  64'hFFFFFFFFFFFFF830);
      run_op("mix_m10_325",   -32'sd10,  32'd325,   64'hFFFFFFFFFFFFF34E);
      run_op("mix_m500_2000", -32'sd500, 32'd2000,  64'hFFFFFFFFFFF0BDC0);
      run_op("mix_m999_999",  -32'sd999, 32'd999,   64'hFFFFFFFFFFF0C58F);
      run_op("same_90_70",    32'd90,    32'd70,    64'h000000000000189C);
      run_op("same_m80_m65",  -32'sd80,  -32'sd65,  64'h0000000000001450);
      run_op("ident_zero",    32'd98756, 32'd0,     64'h0000000000000000);
      run_op("ident_one",     32'd98765, 32'd1,     64'h00000000000181CD);
      run_op("ext_min_min",   32'h80000000, 32'h80000000, 64'h4000000000000000);
      run_op("ext_max_min",   32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000);
      run_op("ext_m1_m1",     32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001);

      // start while busy is ignored
      launch(32'd50, -32'sd40);
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1;
      a     = 32'd7;
      b     = 32'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(k);
      chk("busy_start_ignored", result, 64'hFFFFFFFFFFFFF830);
      repeat (2) @(posedge clk);
      #1;
      chk("busy_start_no_reaccept", 64'(busy), 64'(0));

      // back-to-back: start during the done cycle
      launch(32'd90, 32'd70);
      wait_done(k);
      chk("b2b_first", result, 64'h000000000000189C);
      start = 1'b1;
      a     = -32'sd80;
      b     = -32'sd65;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("b2b_accepted", 64'(busy), 64'(1));
      for (int j = 1; j < LAT; j++) begin
         @(posedge clk);
         #1;
         if (result !== 64'h000000000000189C || done !== 1'b0)
            chk("b2b_hold", result, 64'h000000000000189C);
      end
      @(posedge clk);
      #1;
      chk("b2b_second_done", 64'(done), 64'(1));
      chk("b2b_second",      result,    64'h0000000000001450);

      // reset in the middle of an operation
      launch(-32'sd999, 32'd999);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_result", result,     64'h0);
      chk("abort_busy",   64'(busy),  64'(0));
      chk("abort_done",   64'(done),  64'(0));
      saw_done = 1'b0;
      repeat (LAT + 4) begin
         @(posedge clk);
         #1;
         if (done) saw_done = 1'b1;
      end
      chk("abort_no_done", 64'(saw_done), 64'(0));
      chk("abort_result_held", result, 64'h0);

      run_op("after_abort", 32'd90, 32'd70, 64'h000000000000189C);

      @(negedge clk);
      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/booth_multiplier.md
Name: booth_multiplier

Overview:
- Sequential signed two's-complement multiplier using radix-4 (modified) Booth recoding.
- Multiplies two WIDTH-bit operands into a 2*WIDTH-bit product.
- Processes one Booth digit per clock, with a start/done handshake.
- Sits as a multi-cycle arithmetic unit behind a datapath controller that launches an operation and waits for done.

Parameters:
- WIDTH, 32, operand width in bits; must be even and at least 4. Product width is 2*WIDTH.

Ports:
- clk     input   1          rising-edge clock
- rst     input   1          synchronous, active-high reset
- start   input   1          request a multiply; sampled only when busy=0
- a       input   WIDTH      multiplicand, signed two's complement; sampled with accepted start
- b       input   WIDTH      multiplier, signed two's complement; sampled with accepted start
- busy    output  1          high while an operation is in progress
- done    output  1          single-cycle pulse when result is updated
- result  output  2*WIDTH    signed product a*b; registered and held

Behaviour:
- Reset: when rst is high at a rising edge, result=0, done=0, busy=0, and internal accumulator, counter and operand registers clear. Reset takes priority over everything and aborts any operation in flight; no done pulse is produced for an aborted operation.
- States: IDLE and RUN.
- Accept: in IDLE with start=1 at edge E0, latch a and b, clear the accumulator, set counter=0, busy=1, go to RUN.
- start while busy=1 is ignored; operands are not re-sampled.
- RUN, digit i in 0..WIDTH/2-1, one per edge:
  - Form triplet {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
  - Recode: 000→0, 001→+A, 010→+A, 011→+2A, 100→−2A, 101→−A, 110→−A, 111→0.
  - A is sign-extended to 2*WIDTH bits before doubling or negating. Negation is two's complement.
  - Add the selected partial product shifted left by 2i to the accumulator, modulo 2^(2*WIDTH).
  - A shifting accumulator/multiplier arrangement is acceptable if results are identical.
- Completion: the final digit is processed at edge E(WIDTH/2). At that same edge, result ← final product, done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: WIDTH/2 clocks from the accepting edge to done (16 for WIDTH=32). Throughput: one operation per WIDTH/2+1 cycles at most.
- Back-to-back: start high during the done cycle is accepted, since busy=0.
- result holds its last value until the next completion or reset. It does not change at accept time or while busy.
- Arithmetic: the result equals the exact signed product for all operand pairs, including −2^(WIDTH−1) × −2^(WIDTH−1) = 2^(2*WIDTH−2). There is no overflow in 2*WIDTH bits.
- Zero and one operands need no special-casing.
- done and busy are never high simultaneously.

Test Plan (WIDTH=32, result in 64-bit hex; check done exactly 16 cycles after the accepting edge):
- Reset then idle → result=0000000000000000, done=0, busy=0. Also assert rst in the middle of a multiply → outputs return to 0 on the next edge, no done pulse.
- Mixed signs:
  - a=50, b=−40 → FFFFFFFFFFFFF830
  - a=−10, b=325 → FFFFFFFFFFFFF34E
  - a=−500, b=2000 → FFFFFFFFFFF0BDC0
  - a=−999, b=999 → FFFFFFFFFFF0C58F
- Same signs:
  - a=90, b=70 → 000000000000189C
  - a=−80, b=−65 → 0000000000001450
- Identity and zero:
  - a=98756, b=0 → 0000000000000000
  - a=98765, b=1 → 00000000000181CD
- Extremes:
  - a=b=80000000 → 4000000000000000
  - a=7FFFFFFF, b=80000000 → C000000080000000
  - a=b=FFFFFFFF → 0000000000000001
- Handshake:
  - Pulse start while busy with different operands → ignored; the original product is returned.
  - Assert start during the done cycle → a second operation is accepted, and the first result is held for 16 cycles until the second done.
